ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 127 ++++++++++++
 tb/tb_ram_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a shared single-port RAM; one access per 3 cycles.
// Define RAM_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority to requester 0.
module ram_arbiter #(
    parameter int L_ADDR = 8,
    parameter int L_DATA = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_0,
    input  logic              i_we_0,
    input  logic [L_ADDR-1:0] i_addr_0,
    input  logic [L_DATA-1:0] i_wdata_0,
    input  logic              i_req_1,
    input  logic              i_we_1,
    input  logic [L_ADDR-1:0] i_addr_1,
    input  logic [L_DATA-1:0] i_wdata_1,
    output logic              o_ack_0,
    output logic [L_DATA-1:0] o_rdata_0,
    output logic              o_ack_1,
    output logic [L_DATA-1:0] o_rdata_1,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [L_ADDR-1:0] o_mem_addr,
    output logic [L_DATA-1:0] o_mem_wdata,
    input  logic [L_DATA-1:0] i_mem_rdata
);

    // state  | meaning
    // IDLE   | waiting for a request; grant and latch the RAM command
    // ACCESS | o_mem_en high; read data captured at the closing edge
    // RESP   | grantee's o_ack high; requests ignored
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nxt;
    logic              any_req;
    logic              gnt_sel;
    logic              gnt;
    logic              sel_we;
    logic [L_ADDR-1:0] sel_addr;
    logic [L_DATA-1:0] sel_wdata;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    logic rr_prio;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        any_req = i_req_0 | i_req_1;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
        if (i_req_0 && i_req_1) gnt_sel = rr_prio;
        else                    gnt_sel = i_req_1;
`else
        gnt_sel = ~i_req_0 & i_req_1;
`endif
        sel_we    = gnt_sel ? i_we_1    : i_we_0;
        sel_addr  = gnt_sel ? i_addr_1  : i_addr_0;
        sel_wdata = gnt_sel ? i_wdata_1 : i_wdata_0;
    end

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    // rr_prio names the requester favoured on the next tie
    always_ff @(posedge i_clk) begin
        if (i_rst)                          rr_prio <= 1'b0;
        else if (state == IDLE && any_req)  rr_prio <= ~gnt_sel;
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gnt         <= 1'b0;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_ack_0     <= 1'b0;
            o_ack_1     <= 1'b0;
            o_rdata_0   <= '0;
            o_rdata_1   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt         <= gnt_sel;
                        o_mem_en    <= 1'b1;
                        o_mem_we    <= sel_we;
                        o_mem_addr  <= sel_addr;
                        o_mem_wdata <= sel_wdata;
                    end
                end
                ACCESS: begin
                    o_mem_en <= 1'b0;
                    o_mem_we <= 1'b0;
                    if (gnt) begin
                        o_ack_1 <= 1'b1;
                        if (!o_mem_we) o_rdata_1 <= i_mem_rdata;
                    end else begin
                        o_ack_0 <= 1'b1;
                        if (!o_mem_we) o_rdata_0 <= i_mem_rdata;
                    end
                end
                RESP: begin
                    o_ack_0 <= 1'b0;
                    o_ack_1 <= 1'b0;
                end
                default: begin
                    o_mem_en <= 1'b0;
                    o_mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: table-driven single-requester accesses, then tie, address-hold and reset-abort sequences.
// Expected RAM commands and acks are queued at drive time and popped as the DUT produces them.
module tb_ram_arbiter;

    logic       clk;
    logic       i_rst;
    logic       i_req_0, i_we_0, i_req_1, i_we_1;
    logic [7:0] i_addr_0, i_wdata_0, i_addr_1, i_wdata_1;
    logic       o_ack_0, o_ack_1;
    logic [7:0] o_rdata_0, o_rdata_1;
    logic       o_mem_en, o_mem_we;
    logic [7:0] o_mem_addr, o_mem_wdata;
    logic [7:0] i_mem_rdata;

    ram_arbiter #(.L_ADDR(8), .L_DATA(8)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_req_0(i_req_0), .i_we_0(i_we_0), .i_addr_0(i_addr_0), .i_wdata_0(i_wdata_0),
        .i_req_1(i_req_1), .i_we_1(i_we_1), .i_addr_1(i_addr_1), .i_wdata_1(i_wdata_1),
        .o_ack_0(o_ack_0), .o_rdata_0(o_rdata_0),
        .o_ack_1(o_ack_1), .o_rdata_1(o_rdata_1),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: read data presented while the command is on the bus, write at the closing edge
    logic [7:0] mem [256];
    assign i_mem_rdata = mem[o_mem_addr];
    always @(posedge clk) if (o_mem_en && o_mem_we) mem[o_mem_addr] <= o_mem_wdata;

    typedef struct {
        int         port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } txn_t;

    txn_t       sb[$];
    txn_t       vecs[8];
    logic [7:0] shadow[2];
    int         checks = 0;
    int         errors = 0;
    int         ack_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        txn_t e;
        logic [7:0] rd_own, rd_oth;
        @(negedge clk);
        if (o_ack_0 && o_ack_1) chk("ack_mutex", 1, 0);
        if (o_mem_en) begin
            if (sb.size() == 0) chk("spurious_en", 1, 0);
            else begin
                chk("mem_we", o_mem_we, sb[0].we);
                chk("mem_addr", o_mem_addr, sb[0].addr);
                if (sb[0].we) chk("mem_wdata", o_mem_wdata, sb[0].wdata);
            end
        end
        if (o_ack_0 || o_ack_1) begin
            if (sb.size() == 0) chk("spurious_ack", 1, 0);
            else begin
                e = sb.pop_front();
                ack_cnt++;
                chk("ack_port", o_ack_1 ? 1 : 0, e.port);
                rd_own = (e.port == 1) ? o_rdata_1 : o_rdata_0;
                rd_oth = (e.port == 1) ? o_rdata_0 : o_rdata_1;
                if (!e.we) shadow[e.port] = e.rdata;
                chk("rdata_own", rd_own, shadow[e.port]);
                chk("rdata_other", rd_oth, shadow[1 - e.port]);
            end
        end
    endtask

    task automatic drive(input int port, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        if (port == 0) begin
            i_req_0 = 1'b1; i_we_0 = we; i_addr_0 = addr; i_wdata_0 = wdata;
        end else begin
            i_req_1 = 1'b1; i_we_1 = we; i_addr_1 = addr; i_wdata_1 = wdata;
        end
    endtask

    task automatic run_txn(input txn_t t);
        drive(t.port, t.we, t.addr, t.wdata);
        sb.push_back(t);
        step();
        chk("lat_en", o_mem_en, 1);
        step();
        chk("lat_ack", (t.port == 1) ? o_ack_1 : o_ack_0, 1);
        chk("en_closed", o_mem_en, 0);
        if (t.port == 0) i_req_0 = 1'b0; else i_req_1 = 1'b0;
        step();
        chk("idle_quiet", {o_mem_en, o_ack_0, o_ack_1}, 0);
    endtask

    initial begin
        int   arb_exp[4];
        txn_t t;

        vecs[0] = '{0, 1'b1, 8'h10, 8'h5A, 8'h00};
        vecs[1] = '{0, 1'b0, 8'h10, 8'h00, 8'h5A};
        vecs[2] = '{1, 1'b1, 8'hFF, 8'hC3, 8'h00};
        vecs[3] = '{1, 1'b0, 8'hFF, 8'h00, 8'hC3};
        vecs[4] = '{0, 1'b1, 8'h01, 8'h11, 8'h00};
        vecs[5] = '{1, 1'b1, 8'h02, 8'h22, 8'h00};
        vecs[6] = '{0, 1'b0, 8'h02, 8'h00, 8'h22};
        vecs[7] = '{1, 1'b0, 8'h01, 8'h00, 8'h11};
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
        arb_exp = '{0, 1, 0, 1};
`else
        arb_exp = '{0, 0, 0, 0};
`endif
        shadow[0] = 8'h00;
        shadow[1] = 8'h00;

        // reset with a request pending: nothing may start
        i_rst = 1'b1;
        i_req_0 = 1'b1; i_we_0 = 1'b1; i_addr_0 = 8'hAA; i_wdata_0 = 8'h55;
        i_req_1 = 1'b0; i_we_1 = 1'b0; i_addr_1 = 8'h00; i_wdata_1 = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_no_en", {o_mem_en, o_ack_0, o_ack_1}, 0);
        end
        chk("rst_mem", {o_mem_we, o_mem_addr, o_mem_wdata}, 0);
        chk("rst_rdata", {o_rdata_0, o_rdata_1}, 0);
        i_req_0 = 1'b0;
        i_rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // simultaneous reads held for four grants
        ack_cnt = 0;
        drive(0, 1'b0, 8'h01, 8'h00);
        drive(1, 1'b0, 8'h02, 8'h00);
        for (int i = 0; i < 4; i++) begin
            t = '{arb_exp[i], 1'b0, (arb_exp[i] == 1) ? 8'h02 : 8'h01, 8'h00,
                  (arb_exp[i] == 1) ? 8'h22 : 8'h11};
            sb.push_back(t);
        end
        for (int i = 0; i < 11; i++) step();
        i_req_0 = 1'b0;
        i_req_1 = 1'b0;
        step();
        chk("arb_acks", ack_cnt, 4);
        chk("arb_sb_empty", sb.size(), 0);

        // address and data change after grant must not leak into the transaction
        drive(0, 1'b1, 8'h20, 8'h77);
        sb.push_back('{0, 1'b1, 8'h20, 8'h77, 8'h00});
        step();
        chk("hold_en", o_mem_en, 1);
        i_addr_0 = 8'h30; i_wdata_0 = 8'h99; i_we_0 = 1'b0;
        step();
        chk("hold_addr", o_mem_addr, 8'h20);
        chk("hold_ack", o_ack_0, 1);
        i_req_0 = 1'b0;
        step();
        run_txn('{0, 1'b0, 8'h20, 8'h00, 8'h77});

        // reset during ACCESS aborts with no ack
        drive(1, 1'b0, 8'hFF, 8'h00);
        sb.push_back('{1, 1'b0, 8'hFF, 8'h00, 8'hC3});
        step();
        chk("abort_en", o_mem_en, 1);
        i_rst = 1'b1;
        i_req_1 = 1'b0;
        sb.delete();
        step();
        chk("abort_no_ack", {o_ack_0, o_ack_1}, 0);
        chk("abort_outs", {o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata}, 0);
        chk("abort_rdata", {o_rdata_0, o_rdata_1}, 0);
        shadow[0] = 8'h00;
        shadow[1] = 8'h00;
        i_rst = 1'b0;
        step();
        chk("post_rst_quiet", {o_ack_0, o_ack_1}, 0);
        run_txn('{0, 1'b0, 8'h10, 8'h00, 8'h5A});
        run_txn('{1, 1'b0, 8'hFF, 8'h00, 8'hC3});

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
